// File: rtl/rca8_seq_pkg.sv
// Shared constants and state encoding for the sequential RCA8-based multiplier.
package rca8_seq_pkg;

  // Operand width is fixed by the RCA8 adder it time-shares.
  localparam int W     = 8;
  // One add-and-shift iteration per multiplier bit.
  localparam int ITER  = 8;
  // Iteration counter width.
  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/RCA8.sv
// 8-bit ripple-carry adder/subtractor: z = a + b (sub=0) or a - b (sub=1).
module RCA8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sub,
  output logic [7:0] z,
  output logic       Cout
);

  logic [8:0] c;
  logic [7:0] bx;

  // Two's-complement subtract: invert b and inject the +1 as carry-in.
  assign bx   = b ^ {8{sub}};
  assign c[0] = sub;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign z[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  assign Cout = c[8];

endmodule

// File: rtl/rca8_mult_seq.sv
// Sequential 8x8 unsigned shift-add multiplier reusing one RCA8 instance.
// start accepted in IDLE, 8 RUN iterations, one-cycle DONE with p valid.
module rca8_mult_seq
  import rca8_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          busy,
  output logic          done,
  output logic [2*W-1:0] p
);

  state_e           state_q, state_d;
  logic [W-1:0]     m_q, m_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   p_q, p_d;

  logic [W-1:0]     add_z;
  logic             add_c;
  logic [W-1:0]     sum_s;
  logic             sum_c;

  // Shared adder: accumulator plus multiplicand, add-only.
  RCA8 u_rca8 (
    .a    (a_q),
    .b    (m_q),
    .sub  (1'b0),
    .z    (add_z),
    .Cout (add_c)
  );

  // Partial-product select: add M only when the current multiplier bit is set.
  // The carry must travel with the sum so it lands in A[7] after the shift.
  assign sum_s = q_q[0] ? add_z : a_q;
  assign sum_c = q_q[0] ? add_c : 1'b0;

  // Next-state, datapath and product-load logic.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          a_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = {sum_c, sum_s[W-1:1]};
        q_d   = {sum_s[0], q_q[W-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          p_d     = {a_d, q_d};
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset wins over any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign p    = p_q;

endmodule

// File: tb/tb_rca8_mult_seq.sv
// Directed and random checks for rca8_mult_seq.
module tb_rca8_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] p;

  int checks   = 0;
  int failures = 0;

  rca8_mult_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  // Issue one operation from IDLE and observe it until busy drops (bounded).
  // Sample index i counts edges after the accepting edge; done expected at i=8.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        output logic [15:0] pv, output int done_at,
                        output int bcnt, output int dcnt);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~av; b = ~bv;   // operand changes while busy must not matter
    pv = 16'hxxxx; done_at = -1; bcnt = 0; dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (done_at < 0) begin done_at = i; pv = p; end
      end
      if (!busy) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== 16'h0000) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b p=%h, want 0 0 0000", busy, done, p);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] pv; int da, bc, dc;
    run_op(8'h0D, 8'h0B, pv, da, bc, dc);
    checks++;
    if (pv !== 16'h008F) begin failures++; $display("FAIL basic_p: got %h want 008F", pv); end
    checks++;
    if (da !== 8) begin failures++; $display("FAIL basic_latency: got %0d want 8", da); end
    checks++;
    if (bc !== 9) begin failures++; $display("FAIL basic_busy_cycles: got %0d want 9", bc); end
    checks++;
    if (dc !== 1) begin failures++; $display("FAIL basic_done_pulses: got %0d want 1", dc); end
    // p holds after returning to IDLE
    @(posedge clk); #1;
    checks++;
    if (p !== 16'h008F || busy !== 1'b0) begin
      failures++; $display("FAIL basic_hold: p=%h busy=%b want 008F 0", p, busy);
    end
  endtask

  task automatic test_vectors();
    logic [7:0]  va [5] = '{8'hFF, 8'h00, 8'h80, 8'h01, 8'h0F};
    logic [7:0]  vb [5] = '{8'hFF, 8'hFF, 8'h02, 8'h80, 8'hF0};
    logic [15:0] vp [5] = '{16'hFE01, 16'h0000, 16'h0100, 16'h0080, 16'h0E10};
    logic [15:0] pv; int da, bc, dc;
    for (int k = 0; k < 5; k++) begin
      run_op(va[k], vb[k], pv, da, bc, dc);
      checks++;
      if (pv !== vp[k] || da !== 8) begin
        failures++;
        $display("FAIL vec_%0d: %h*%h got p=%h at %0d want %h at 8", k, va[k], vb[k], pv, da, vp[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nd = 0; int t0 = -1, t1 = -1;
    logic [15:0] p0 = 'x, p1 = 'x;
    a = 8'd3; b = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    a = 8'd7; b = 8'd9;
    for (int i = 0; i < 25; i++) begin
      if (done) begin
        nd++;
        if (nd == 1) begin t0 = i; p0 = p; end
        else if (nd == 2) begin t1 = i; p1 = p; start = 1'b0; end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (p0 !== 16'h000F || t0 !== 8) begin
      failures++; $display("FAIL b2b_first: p=%h at %0d want 000F at 8", p0, t0);
    end
    checks++;
    if (p1 !== 16'h003F || t1 !== 18) begin
      failures++; $display("FAIL b2b_second: p=%h at %0d want 003F at 18", p1, t1);
    end
    checks++;
    if (nd !== 2) begin failures++; $display("FAIL b2b_pulses: got %0d want 2", nd); end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] pv; int da, bc, dc;
    a = 8'hFF; b = 8'h02; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== 16'h0000) begin
      failures++;
      $display("FAIL midrun_reset: busy=%b done=%b p=%h want 0 0 0000", busy, done, p);
    end
    run_op(8'd2, 8'd3, pv, da, bc, dc);
    checks++;
    if (pv !== 16'h0006 || da !== 8) begin
      failures++; $display("FAIL after_reset: p=%h at %0d want 0006 at 8", pv, da);
    end
  endtask

  task automatic test_random();
    logic [15:0] pv; int da, bc, dc;
    logic [7:0] ra, rb;
    for (int k = 0; k < 500; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, pv, da, bc, dc);
      checks++;
      if (pv !== 16'(ra) * 16'(rb) || da !== 8 || bc !== 9 || dc !== 1) begin
        failures++;
        $display("FAIL rand_%0d: %h*%h got p=%h done_at=%0d busy=%0d pulses=%0d want %h 8 9 1",
                 k, ra, rb, pv, da, bc, dc, 16'(ra) * 16'(rb));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
